// File: rtl/rgb_pkg.sv
// Shared types, default palette and cross-fade helper for the RGB colour sequencer.
package rgb_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam int MAX_COLORS = 16;
    localparam int MAX_IW     = $clog2(MAX_COLORS);

    // Red, yellow, green, cyan, blue, magenta; unused slots are dark.
    localparam rgb_t PALETTE [MAX_COLORS] = '{
        rgb_t'(24'hFF0000), rgb_t'(24'hFFFF00), rgb_t'(24'h00FF00), rgb_t'(24'h00FFFF),
        rgb_t'(24'h0000FF), rgb_t'(24'hFF00FF), rgb_t'(24'h000000), rgb_t'(24'h000000),
        rgb_t'(24'h000000), rgb_t'(24'h000000), rgb_t'(24'h000000), rgb_t'(24'h000000),
        rgb_t'(24'h000000), rgb_t'(24'h000000), rgb_t'(24'h000000), rgb_t'(24'h000000)
    };

    // Linear mix of one channel: frac = 0 yields cur exactly, the sum never exceeds 255*256.
    function automatic logic [7:0] blend_ch(input logic [7:0] cur,
                                            input logic [7:0] nxt,
                                            input logic [7:0] frac);
        logic [15:0] acc;
        acc = 16'(cur) * (16'd256 - 16'(frac)) + 16'(nxt) * 16'(frac);
        return acc[15:8];
    endfunction

    function automatic rgb_t blend(input rgb_t cur, input rgb_t nxt, input logic [7:0] frac);
        rgb_t res;
        res.r = blend_ch(cur.r, nxt.r, frac);
        res.g = blend_ch(cur.g, nxt.g, frac);
        res.b = blend_ch(cur.b, nxt.b, frac);
        return res;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM colour channel: latches its level at the period boundary and drives an active-low pin.
module pwm_channel #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                latch,
    input  logic [7:0]          level,
    input  logic                blank,
    output logic                led_n
);

    logic [7:0] level_q, level_d;
    logic       led_n_q, led_n_d;
    logic [8:0] thresh;

    // Level capture at the period boundary and the registered pin compare.
    always_comb begin
        level_d = latch ? level : level_q;
        // pwm_cnt < level[7 -: PWM_BITS] is the same test as (pwm_cnt + 1) << (8 - PWM_BITS) <= level,
        // which keeps the full 8-bit level meaningful for any PWM_BITS.
        thresh  = (9'(pwm_cnt) + 9'd1) << (8 - PWM_BITS);
        led_n_d = blank | ~(thresh <= {1'b0, level_q});
    end

    // Level and pin registers; the pin resets dark.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_q <= '0;
            led_n_q <= 1'b1;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values regardless of block order.
            level_q <= level_d;
            led_n_q <= led_n_d;
        end
    end

    assign led_n = led_n_q;

endmodule

// File: rtl/rgb_color_sequencer.sv
// Palette sequencer for an active-low RGB LED: step or cross-fade through N_COLORS entries with PWM dimming.
module rgb_color_sequencer
    import rgb_pkg::*;
#(
    parameter  int N_COLORS = 6,
    parameter  int PWM_BITS = 8,
    parameter  int TICK_DIV = 46875,
    localparam int IW       = $clog2(N_COLORS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          fade,
    input  logic          blank,
    input  logic          load,
    input  logic [IW-1:0] load_idx,
    output logic [IW-1:0] color_idx,
    output logic          step,
    output logic          wrap,
    output logic          RGB_R,
    output logic          RGB_G,
    output logic          RGB_B
);

    localparam int            TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int            P         = (1 << PWM_BITS) - 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(N_COLORS - 1);

    logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
    logic [7:0]          frac_q, frac_d;
    logic [IW-1:0]       idx_q, idx_d, nxt_idx;
    logic                step_q, step_d, wrap_q, wrap_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                tick, pwm_latch;
    rgb_t                cur_rgb, nxt_rgb, target;

    assign tick      = enable && (tick_cnt_q == TICK_LAST);
    assign nxt_idx   = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
    assign pwm_latch = (pwm_cnt_q == PWM_BITS'(P - 1));

    // Index/fraction/tick sequencing; a load wins over a coincident advance and never pulses step/wrap.
    always_comb begin
        // NOTE: defaults first, so no branch can leave a signal unassigned and infer a latch.
        tick_cnt_d = tick_cnt_q;
        frac_d     = frac_q;
        idx_d      = idx_q;
        step_d     = 1'b0;
        wrap_d     = 1'b0;
        if (load) begin
            idx_d      = (32'(load_idx) < 32'(N_COLORS)) ? load_idx : '0;
            frac_d     = '0;
            tick_cnt_d = '0;
        end else if (enable) begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
            if (tick) begin
                frac_d = frac_q + 8'd1;
                if (frac_q == 8'hFF) begin
                    idx_d  = nxt_idx;
                    step_d = 1'b1;
                    wrap_d = (idx_q == LAST_IDX);
                end
            end
        end
    end

    // Free-running PWM period counter and the per-channel target level.
    always_comb begin
        pwm_cnt_d = pwm_latch ? '0 : pwm_cnt_q + PWM_BITS'(1);
        cur_rgb   = PALETTE[MAX_IW'(idx_q)];
        nxt_rgb   = PALETTE[MAX_IW'(nxt_idx)];
        target    = fade ? blend(cur_rgb, nxt_rgb, frac_q) : cur_rgb;
    end

    // Sequencer and PWM counter state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt_q <= '0;
            frac_q     <= '0;
            idx_q      <= '0;
            step_q     <= 1'b0;
            wrap_q     <= 1'b0;
            pwm_cnt_q  <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            frac_q     <= frac_d;
            idx_q      <= idx_d;
            step_q     <= step_d;
            wrap_q     <= wrap_d;
            pwm_cnt_q  <= pwm_cnt_d;
        end
    end

    assign color_idx = idx_q;
    assign step      = step_q;
    assign wrap      = wrap_q;

    pwm_channel #(.PWM_BITS(PWM_BITS)) u_red (
        .clk(clk), .rst(rst), .pwm_cnt(pwm_cnt_q), .latch(pwm_latch),
        .level(target.r), .blank(blank), .led_n(RGB_R)
    );

    pwm_channel #(.PWM_BITS(PWM_BITS)) u_green (
        .clk(clk), .rst(rst), .pwm_cnt(pwm_cnt_q), .latch(pwm_latch),
        .level(target.g), .blank(blank), .led_n(RGB_G)
    );

    pwm_channel #(.PWM_BITS(PWM_BITS)) u_blue (
        .clk(clk), .rst(rst), .pwm_cnt(pwm_cnt_q), .latch(pwm_latch),
        .level(target.b), .blank(blank), .led_n(RGB_B)
    );

endmodule

// File: tb/tb_rgb_color_sequencer.sv
// Bench for rgb_color_sequencer: a position/time model checked every cycle plus literal scenario checks.
module tb_rgb_color_sequencer;

    localparam int N     = 6;
    localparam int PB    = 4;
    localparam int TD    = 2;
    localparam int IW    = 3;
    localparam int P     = (1 << PB) - 1;
    localparam int DWELL = 256 * TD;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          enable   = 1'b0;
    logic          fade     = 1'b0;
    logic          blank    = 1'b0;
    logic          load     = 1'b0;
    logic [IW-1:0] load_idx = '0;
    logic [IW-1:0] color_idx;
    logic          step, wrap, RGB_R, RGB_G, RGB_B;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rgb_color_sequencer #(.N_COLORS(N), .PWM_BITS(PB), .TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .enable(enable), .fade(fade), .blank(blank),
        .load(load), .load_idx(load_idx), .color_idx(color_idx),
        .step(step), .wrap(wrap), .RGB_R(RGB_R), .RGB_G(RGB_G), .RGB_B(RGB_B)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Position counts enabled cycles within one palette lap: idx = pos / DWELL, frac = (pos % DWELL) / TD.
    int pal [N][3] = '{'{255, 0, 0}, '{255, 255, 0}, '{0, 255, 0},
                       '{0, 255, 255}, '{0, 0, 255}, '{255, 0, 255}};
    int m_pos, m_cyc, m_phase;
    int m_lvl [3];
    bit m_pin [3];
    bit m_step, m_wrap;
    bit m_valid = 1'b0;

    function automatic int model_level(int pos, int ch, bit fd);
        int idx, frac, cur, nxt;
        idx  = pos / DWELL;
        frac = (pos % DWELL) / TD;
        cur  = pal[idx][ch];
        nxt  = pal[(idx + 1) % N][ch];
        return fd ? (cur * (256 - frac) + nxt * frac) / 256 : cur;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pos = 0; m_cyc = 0; m_step = 0; m_wrap = 0; m_valid = 1'b1;
            for (int ch = 0; ch < 3; ch++) begin m_lvl[ch] = 0; m_pin[ch] = 1'b1; end
        end else begin
            m_phase = m_cyc % P;
            for (int ch = 0; ch < 3; ch++)
                m_pin[ch] = blank || (m_phase >= (m_lvl[ch] >> (8 - PB)));
            if (m_phase == P - 1)
                for (int ch = 0; ch < 3; ch++) m_lvl[ch] = model_level(m_pos, ch, fade);
            m_cyc++;
            m_step = 0;
            m_wrap = 0;
            if (load) begin
                m_pos = (int'(load_idx) < N) ? int'(load_idx) * DWELL : 0;
            end else if (enable) begin
                m_pos++;
                if (m_pos % DWELL == 0) m_step = 1;
                if (m_pos == N * DWELL) begin m_pos = 0; m_wrap = 1; end
            end
        end
    end

    // Compare process: outputs against the model on every falling edge once reset has been seen.
    always @(negedge clk) begin
        if (m_valid) begin
            check("model color_idx", 32'(color_idx), 32'(m_pos / DWELL));
            check("model step", 32'(step), 32'(m_step));
            check("model wrap", 32'(wrap), 32'(m_wrap));
            check("model RGB_R", 32'(RGB_R), 32'(m_pin[0]));
            check("model RGB_G", 32'(RGB_G), 32'(m_pin[1]));
            check("model RGB_B", 32'(RGB_B), 32'(m_pin[2]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick1();
        @(negedge clk);
        #1;
    endtask

    task automatic assert_reset();
        tick1();
        rst = 1'b0;
        #1;
        check("reset color_idx", 32'(color_idx), 32'd0);
        check("reset pins", 32'({RGB_R, RGB_G, RGB_B}), 32'b111);
        check("reset step/wrap", 32'({step, wrap}), 32'b00);
        repeat (3) tick1();
    endtask

    int first_step, steps, wraps, r_low, g_low, b_low, g_high, b_high, r_high, g_low_early, g_toggles, dark_miss;
    logic prev_g;

    initial begin
        // Step mode through a full palette lap from reset.
        assert_reset();
        enable = 1'b1; fade = 1'b0;
        rst = 1'b1;
        first_step = 0; steps = 0; wraps = 0; r_low = 0; g_high = 0; b_high = 0;
        for (int t = 1; t <= N * DWELL; t++) begin
            tick1();
            if (step) begin steps++; if (first_step == 0) first_step = t; end
            if (wrap) wraps++;
            if (t >= 100 && t < 115) begin
                if (!RGB_R) r_low++;
                if (RGB_G)  g_high++;
                if (RGB_B)  b_high++;
            end
        end
        check("first step after reset", first_step, 512);
        check("steps per lap", steps, 6);
        check("wraps per lap", wraps, 1);
        check("idx after lap", 32'(color_idx), 0);
        check("red R duty", r_low, 15);
        check("red G dark", g_high, 15);
        check("red B dark", b_high, 15);

        // Reset asserted mid-fade while at index 1.
        fade = 1'b1;
        repeat (700) tick1();
        check("idx before mid-fade reset", 32'(color_idx), 1);
        assert_reset();
        enable = 1'b1; fade = 1'b1;
        rst = 1'b1;

        // Freeze red->yellow at frac 128 for 1000 cycles.
        repeat (256) tick1();
        enable = 1'b0;
        g_toggles = 0; g_low_early = 0; g_low = 0; r_low = 0; b_low = 0;
        prev_g = RGB_G;
        for (int t = 257; t <= 1256; t++) begin
            tick1();
            if (RGB_G !== prev_g) g_toggles++;
            prev_g = RGB_G;
            if (t >= 300 && t < 315 && !RGB_G) g_low_early++;
            if (t > 1241) begin
                if (!RGB_G) g_low++;
                if (!RGB_R) r_low++;
                if (!RGB_B) b_low++;
            end
        end
        check("hold idx", 32'(color_idx), 0);
        check("fade G duty early", g_low_early, 7);
        check("fade G duty late", g_low, 7);
        check("fade R duty", r_low, 15);
        check("fade B duty", b_low, 0);
        check("G toggles while held", 32'(g_toggles > 0), 1);
        enable = 1'b1;
        first_step = 0;
        for (int t = 1257; t <= 3000; t++) begin
            tick1();
            if (step) begin first_step = t; break; end
        end
        check("advance delayed by hold", first_step, 1512);

        // Load coinciding with the advancing tick, then out-of-range loads.
        assert_reset();
        enable = 1'b1; fade = 1'b0;
        rst = 1'b1;
        repeat (511) tick1();
        check("idx before load", 32'(color_idx), 0);
        load = 1'b1; load_idx = 3'd4;
        tick1();
        load = 1'b0;
        check("load beats advance", 32'(color_idx), 4);
        check("no step on load", 32'(step), 0);
        // An index of 9 does not fit the 3-bit port; 6 and 7 are the out-of-range codes.
        load = 1'b1; load_idx = 3'd7;
        tick1();
        load = 1'b0;
        check("load 7 gives 0", 32'(color_idx), 0);
        load = 1'b1; load_idx = 3'd6;
        tick1();
        load = 1'b0;
        check("load 6 gives 0", 32'(color_idx), 0);

        // Blank while showing green.
        load = 1'b1; load_idx = 3'd2;
        tick1();
        load = 1'b0;
        repeat (40) tick1();
        blank = 1'b1;
        tick1();
        check("blank next cycle", 32'({RGB_R, RGB_G, RGB_B}), 32'b111);
        dark_miss = 0;
        repeat (20) begin
            tick1();
            if ({RGB_R, RGB_G, RGB_B} != 3'b111) dark_miss++;
        end
        check("blank held", dark_miss, 0);
        blank = 1'b0;
        repeat (30) tick1();
        g_low = 0; r_high = 0; b_high = 0;
        repeat (15) begin
            tick1();
            if (!RGB_G) g_low++;
            if (RGB_R)  r_high++;
            if (RGB_B)  b_high++;
        end
        check("green G duty", g_low, 15);
        check("green R dark", r_high, 15);
        check("green B dark", b_high, 15);
        check("idx after blank", 32'(color_idx), 2);

        // Randomised traffic against the model.
        fade = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            enable   = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 199) == 0) fade = ~fade;
            blank    = ($urandom_range(0, 39) == 0);
            load     = ($urandom_range(0, 599) == 0);
            load_idx = IW'($urandom_range(0, 7));
            tick1();
        end
        load = 1'b0; blank = 1'b0;
        repeat (2) tick1();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

endmodule
